p_flag_sequencer: RTL and testbench

Sequences every write to the CPU status register (P/E/M/X) from one place. It arbitrates between instruction flag operations (REP, SEP, PLP/RTI, XCE, interrupt entry) and ALU flag updates. It converts each accepted request into one cycle of per-bit write strobes, or an XCE strobe, toward the status register. After mode-changing operations it detects the X 0→1 transition and pulses an index-truncate request for the X/Y register file. It sits between the CPU microcode sequencer/ALU and the status register.

---
 rtl/p_flag_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_p_flag_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_flag_sequencer.sv
// rtl/p_flag_sequencer.sv - status register write sequencer for flag ops and ALU updates; debug trace via PSEQ_TRACE_EN
`timescale 1ns/1ps
module p_flag_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [7:0]  alu_flags,
    input  logic [7:0]  alu_mask,
    input  logic [7:0]  p_in,
    input  logic        e_in,
    input  logic        m_in,
    input  logic        x_in,
    output logic [7:0]  p_wdata,
    output logic [7:0]  p_write,
    output logic        p_xce,
    output logic        idx_trunc,
    output logic        busy,
    output logic [15:0] trace_cnt,
    output logic [3:0]  trace_last_op
);

    localparam logic [3:0] OP_REP = 4'd1;
    localparam logic [3:0] OP_SEP = 4'd2;
    localparam logic [3:0] OP_PLP = 4'd3;
    localparam logic [3:0] OP_XCE = 4'd4;
    localparam logic [3:0] OP_INT = 4'd5;

    // Bits 5:4 (M/X, or B in emulation) are kept out of ALU writes and emulation-mode flag ops.
    localparam logic [7:0] KEEP_MX = 8'hCF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       is_cmd_q, is_cmd_d;
    logic       x_old_q, x_old_d;
    logic [7:0] p_wdata_q, p_wdata_d;
    logic [7:0] p_write_q, p_write_d;
    logic       p_xce_q, p_xce_d;

    logic       cmd_fire;
    logic       alu_fire;
    logic       settle_exit;
    logic [7:0] dec_wdata;
    logic [7:0] dec_write;
    logic       dec_xce;

    // The current P and M are owned by the status register; M follows X handling elsewhere.
    logic unused_inputs;
    assign unused_inputs = ^{p_in, m_in};

    // Handshakes: cmd wins over alu, nothing is accepted outside IDLE or during reset.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE) && !reset;
        alu_ready   = (state_q == S_IDLE) && !cmd_valid && !reset;
        cmd_fire    = cmd_valid && cmd_ready && cpu_en;
        alu_fire    = alu_valid && alu_ready && cpu_en;
        settle_exit = (state_q == S_SETTLE) && cpu_en;
    end

    // Translate an instruction flag op into write data, per-bit strobes and the XCE strobe.
    always_comb begin
        dec_wdata = 8'h00;
        dec_write = 8'h00;
        dec_xce   = 1'b0;
        case (cmd_op)
            OP_REP: begin
                dec_wdata = 8'h00;
                dec_write = cmd_data;
            end
            OP_SEP: begin
                dec_wdata = 8'hFF;
                dec_write = cmd_data;
            end
            OP_PLP: begin
                dec_wdata = cmd_data;
                dec_write = 8'hFF;
            end
            OP_XCE: begin
                dec_xce = 1'b1;
            end
            OP_INT: begin
                dec_wdata = 8'h04;
                dec_write = 8'h0C;
            end
            default: begin
                dec_wdata = 8'h00;
                dec_write = 8'h00;
            end
        endcase
        if (e_in && ((cmd_op == OP_REP) || (cmd_op == OP_SEP) || (cmd_op == OP_PLP))) begin
            dec_write = dec_write & KEEP_MX;
        end
    end

    // Next-state and registered strobe computation for the IDLE/APPLY/SETTLE sequence.
    always_comb begin
        state_d   = state_q;
        is_cmd_d  = is_cmd_q;
        x_old_d   = x_old_q;
        p_wdata_d = p_wdata_q;
        p_write_d = p_write_q;
        p_xce_d   = p_xce_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d   = S_APPLY;
                    is_cmd_d  = 1'b1;
                    x_old_d   = x_in;
                    p_wdata_d = dec_wdata;
                    p_write_d = dec_write;
                    p_xce_d   = dec_xce;
                end else if (alu_fire) begin
                    state_d   = S_APPLY;
                    is_cmd_d  = 1'b0;
                    p_wdata_d = alu_flags;
                    p_write_d = alu_mask & KEEP_MX;
                    p_xce_d   = 1'b0;
                end
            end
            S_APPLY: begin
                if (cpu_en) begin
                    p_wdata_d = 8'h00;
                    p_write_d = 8'h00;
                    p_xce_d   = 1'b0;
                    state_d   = is_cmd_q ? S_SETTLE : S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cpu_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and strobe registers; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            is_cmd_q  <= 1'b0;
            x_old_q   <= 1'b0;
            p_wdata_q <= 8'h00;
            p_write_q <= 8'h00;
            p_xce_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_cmd_q  <= is_cmd_d;
            x_old_q   <= x_old_d;
            p_wdata_q <= p_wdata_d;
            p_write_q <= p_write_d;
            p_xce_q   <= p_xce_d;
        end
    end

    // X rising across the op (SEP #$10, PLP, XCE into emulation) means X/Y high bytes must be cleared.
    assign idx_trunc = settle_exit && !reset && !x_old_q && x_in;

    assign p_wdata = p_wdata_q;
    assign p_write = p_write_q;
    assign p_xce   = p_xce_q;
    assign busy    = (state_q != S_IDLE);

`ifdef PSEQ_TRACE_EN
    logic [15:0] trace_cnt_q, trace_cnt_d;
    logic [3:0]  trace_last_op_q, trace_last_op_d;

    // Count completed flag ops and remember the most recently accepted opcode.
    always_comb begin
        trace_cnt_d     = trace_cnt_q;
        trace_last_op_d = trace_last_op_q;
        if (settle_exit) begin
            trace_cnt_d = trace_cnt_q + 16'd1;
        end
        if (cmd_fire) begin
            trace_last_op_d = cmd_op;
        end
    end

    // Trace registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_cnt_q     <= 16'h0000;
            trace_last_op_q <= 4'h0;
        end else begin
            trace_cnt_q     <= trace_cnt_d;
            trace_last_op_q <= trace_last_op_d;
        end
    end

    assign trace_cnt     = trace_cnt_q;
    assign trace_last_op = trace_last_op_q;
`else
    assign trace_cnt     = 16'h0000;
    assign trace_last_op = 4'h0;
`endif

endmodule

// File: tb/tb_p_flag_sequencer.sv
// tb/tb_p_flag_sequencer.sv - bench for p_flag_sequencer: status register model, transaction-level reference, directed and random stimulus
`timescale 1ns/1ps
module tb_p_flag_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cpu_en, cmd_valid, alu_valid;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_data, alu_flags, alu_mask;
    logic        cmd_ready, alu_ready;
    logic [7:0]  p_wdata, p_write;
    logic        p_xce, idx_trunc, busy;
    logic [15:0] trace_cnt;
    logic [3:0]  trace_last_op;

    // Status register seen by the sequencer.
    logic [7:0] env_p = 8'h00;
    logic       env_e = 1'b0;
    logic [7:0] p_in;
    logic       e_in, m_in, x_in;
    assign p_in = env_p;
    assign e_in = env_e;
    assign m_in = env_p[5];
    assign x_in = env_p[4];

    p_flag_sequencer dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_flags(alu_flags), .alu_mask(alu_mask),
        .p_in(p_in), .e_in(e_in), .m_in(m_in), .x_in(x_in),
        .p_wdata(p_wdata), .p_write(p_write), .p_xce(p_xce),
        .idx_trunc(idx_trunc), .busy(busy),
        .trace_cnt(trace_cnt), .trace_last_op(trace_last_op)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Strobes sampled mid-cycle, applied to the status register on the next enabled edge.
    logic [7:0] s_wd, s_wr;
    logic       s_xc;
    logic [7:0] nxt_p;
    logic       nxt_e;
    always @(negedge clk) begin
        s_wd = p_wdata;
        s_wr = p_write;
        s_xc = p_xce;
    end
    always @(posedge clk) begin
        if (cpu_en) begin
            nxt_p = env_p;
            nxt_e = env_e;
            for (int i = 0; i < 8; i++) if (s_wr[i]) nxt_p[i] = s_wd[i];
            if (s_xc) begin
                nxt_e    = env_p[0];
                nxt_p[0] = env_e;
            end
            if (nxt_e) nxt_p[5:4] = 2'b11;
            env_p <= nxt_p;
            env_e <= nxt_e;
        end
    end

    // Reference: an op occupies the block for a fixed number of enabled cycles; strobes show in the first.
    bit          m_started = 0;
    bit          m_active = 0;
    int          m_age = 0;
    int          m_len = 0;
    bit          m_is_cmd = 0;
    bit          m_x_old = 0;
    logic [7:0]  m_wd = 0, m_wr = 0;
    logic        m_xc = 0;
    logic [15:0] m_tcnt = 0;
    logic [3:0]  m_tlast = 0;

    function automatic void ref_strobes(input logic [3:0] op, input logic [7:0] d, input logic e,
                                        output logic [7:0] wd, output logic [7:0] wr, output logic xc);
        wd = 8'h00; wr = 8'h00; xc = 1'b0;
        case (op)
            4'd1: begin wd = 8'h00; wr = d; end
            4'd2: begin wd = 8'hFF; wr = d; end
            4'd3: begin wd = d; wr = 8'hFF; end
            4'd4: xc = 1'b1;
            4'd5: begin wd = 8'h04; wr = 8'h0C; end
            default: ;
        endcase
        if (e && (op >= 4'd1) && (op <= 4'd3)) wr = wr & 8'hCF;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_started = 1;
            m_active  = 0;
            m_age     = 0;
            m_tcnt    = 0;
            m_tlast   = 0;
        end else if (m_started && cpu_en) begin
            if (m_active) begin
                m_age++;
                if (m_age == m_len) begin
                    m_active = 0;
                    if (m_is_cmd) m_tcnt++;
                end
            end else if (cmd_valid) begin
                m_active = 1; m_age = 1; m_len = 3; m_is_cmd = 1;
                m_x_old  = x_in;
                m_tlast  = cmd_op;
                ref_strobes(cmd_op, cmd_data, e_in, m_wd, m_wr, m_xc);
            end else if (alu_valid) begin
                m_active = 1; m_age = 1; m_len = 2; m_is_cmd = 0;
                m_wd = alu_flags;
                m_wr = alu_mask & 8'hCF;
                m_xc = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the reference.
    bit on;
    always @(negedge clk) begin
        if (m_started) begin
            on = m_active && (m_age == 1);
            chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, !m_active && !reset});
            chk("alu_ready", {15'd0, alu_ready}, {15'd0, !m_active && !cmd_valid && !reset});
            chk("busy",      {15'd0, busy},      {15'd0, m_active});
            chk("p_wdata",   {8'd0, p_wdata},    {8'd0, on ? m_wd : 8'h00});
            chk("p_write",   {8'd0, p_write},    {8'd0, on ? m_wr : 8'h00});
            chk("p_xce",     {15'd0, p_xce},     {15'd0, on && m_xc});
            chk("idx_trunc", {15'd0, idx_trunc},
                {15'd0, m_active && m_is_cmd && (m_age == 2) && cpu_en && !reset && !m_x_old && x_in});
`ifdef PSEQ_TRACE_EN
            chk("trace_cnt",     trace_cnt,             m_tcnt);
            chk("trace_last_op", {12'd0, trace_last_op}, {12'd0, m_tlast});
`else
            chk("trace_cnt",     trace_cnt,             16'h0000);
            chk("trace_last_op", {12'd0, trace_last_op}, 16'h0000);
`endif
        end
    end

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] d);
        bit ok = 0;
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = cmd_ready && cpu_en;
            n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_accept_timeout: op %h not accepted within 50 cycles", op);
        end
    endtask

    task automatic send_alu(input logic [7:0] f, input logic [7:0] m);
        bit ok = 0;
        int n = 0;
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_flags = f; alu_mask = m;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = alu_ready && cpu_en;
            n++;
            @(posedge clk); #1;
        end
        alu_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL alu_accept_timeout: mask %h not accepted within 50 cycles", m);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  iters;
        bit  ok;
        reset = 1'b1; cpu_en = 1'b1; cmd_valid = 1'b0; alu_valid = 1'b0;
        cmd_op = 4'd0; cmd_data = 8'h00; alu_flags = 8'h00; alu_mask = 8'h00;

        // Reset: handshakes low during reset, idle afterwards.
        @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        chk("rst_alu_ready", {15'd0, alu_ready}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("post_rst_busy",      {15'd0, busy},      16'd0);
        chk("post_rst_p_write",   {8'd0, p_write},    16'h0000);

        // Native SEP #$10: strobes, then idx_trunc, then one completed op.
        send_cmd(4'd2, 8'h10);
        @(negedge clk);
        chk("sep_wdata", {8'd0, p_wdata}, 16'h00FF);
        chk("sep_write", {8'd0, p_write}, 16'h0010);
        @(negedge clk);
        chk("sep_idx_trunc", {15'd0, idx_trunc}, 16'd1);
        @(negedge clk);
        chk("sep_busy_done", {15'd0, busy}, 16'd0);
`ifdef PSEQ_TRACE_EN
        chk("sep_trace_cnt", trace_cnt, 16'd1);
`else
        chk("sep_trace_cnt", trace_cnt, 16'd0);
`endif

        // Clear M/X, set C, then XCE into emulation.
        send_cmd(4'd1, 8'h30);
        send_cmd(4'd2, 8'h01);
        send_cmd(4'd4, 8'h00);
        @(negedge clk);
        chk("xce_p_xce", {15'd0, p_xce}, 16'd1);
        chk("xce_write", {8'd0, p_write}, 16'h0000);
        @(negedge clk);
        chk("xce_idx_trunc", {15'd0, idx_trunc}, 16'd1);
        chk("xce_e_in", {15'd0, e_in}, 16'd1);

        // Emulation REP #$30 leaves M/X alone.
        send_cmd(4'd1, 8'h30);
        @(negedge clk);
        chk("emu_rep_write", {8'd0, p_write}, 16'h0000);
        @(negedge clk);
        chk("emu_rep_idx", {15'd0, idx_trunc}, 16'd0);
        chk("emu_rep_mx", {14'd0, p_in[5:4]}, 16'd3);

        // Clear C, XCE back to native: X was already 1, so no truncation.
        send_cmd(4'd1, 8'h01);
        send_cmd(4'd4, 8'h00);
        @(negedge clk);
        chk("xce2_p_xce", {15'd0, p_xce}, 16'd1);
        @(negedge clk);
        chk("xce2_idx", {15'd0, idx_trunc}, 16'd0);
        chk("xce2_e_in", {15'd0, e_in}, 16'd0);

        // INT_ENTRY and ALU together: cmd first, ALU two waits later.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'd5; cmd_data = 8'h00;
        alu_valid = 1'b1; alu_flags = 8'h5A; alu_mask = 8'hC3;
        @(negedge clk);
        chk("both_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("both_alu_ready", {15'd0, alu_ready}, 16'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("int_write", {8'd0, p_write}, 16'h000C);
        chk("int_wdata", {8'd0, p_wdata}, 16'h0004);
        iters = 0; ok = 0;
        while (!ok && iters < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            iters++;
            ok = alu_ready && cpu_en;
        end
        chk("alu_wait", iters[15:0], 16'd2);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_write", {8'd0, p_write}, 16'h00C3);
        chk("alu_wdata", {8'd0, p_wdata}, 16'h005A);
        send_alu(8'h00, 8'hFF);
        @(negedge clk);
        chk("alu_ff_write", {8'd0, p_write}, 16'h00CF);

        // cpu_en 1,0,0,1 while strobes are pending: held, then applied once.
        send_cmd(4'd2, 8'h08);
        cpu_en = 1'b0;
        @(negedge clk);
        chk("hold0_write", {8'd0, p_write}, 16'h0008);
        chk("hold0_busy",  {15'd0, busy},   16'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold1_write", {8'd0, p_write}, 16'h0008);
        @(posedge clk); #1;
        cpu_en = 1'b1;
        @(negedge clk);
        chk("hold2_write", {8'd0, p_write}, 16'h0008);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_done_write", {8'd0, p_write}, 16'h0000);
        chk("hold_d_flag", {15'd0, p_in[3]}, 16'd1);

        // Reset during SETTLE suppresses idx_trunc.
        send_cmd(4'd1, 8'h10);
        send_cmd(4'd2, 8'h10);
        @(negedge clk);
        chk("rs_write", {8'd0, p_write}, 16'h0010);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rs_idx", {15'd0, idx_trunc}, 16'd0);
        chk("rs_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rs_busy", {15'd0, busy}, 16'd0);
        chk("rs_cmd_ready_back", {15'd0, cmd_ready}, 16'd1);
        chk("rs_p_write", {8'd0, p_write}, 16'h0000);

        // Random traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 299) == 0);
            cpu_en    = ($urandom_range(0, 3) != 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) cmd_op = 4'($urandom_range(1, 5));
            cmd_data  = 8'($urandom_range(0, 255));
            alu_valid = ($urandom_range(0, 1) == 0);
            alu_flags = 8'($urandom_range(0, 255));
            alu_mask  = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        reset = 1'b0; cpu_en = 1'b1; cmd_valid = 1'b0; alu_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
